// File: rtl/dma_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dma_arbiter : round-robin arbiter handing 4 channel descriptors to one   |
// |               DMA engine. Optional watchdog via DMA_ARB_WATCHDOG_EN.     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module dma_arbiter #(
  parameter int N_CH     = 4,
  parameter int WD_LIMIT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      ch_req,
  input  logic [32*N_CH-1:0]   ch_src_addr,
  input  logic [32*N_CH-1:0]   ch_dest_addr,
  input  logic [32*N_CH-1:0]   ch_length,
  output logic [N_CH-1:0]      ch_ack,
  output logic [N_CH-1:0]      ch_done,
  output logic [1:0]           grant_id,
  output logic                 arb_busy,
  output logic                 dma_start,
  output logic [31:0]          dma_src_addr,
  output logic [31:0]          dma_dest_addr,
  output logic [31:0]          dma_length,
  input  logic                 dma_busy,
  output logic                 dma_timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_last_grant;
  logic [1:0]        r_grant;
  logic [N_CH-1:0]   r_ch_ack;
  logic [N_CH-1:0]   r_ch_done;
  logic              r_arb_busy;
  logic              r_dma_start;
  logic [31:0]       r_dma_src;
  logic [31:0]       r_dma_dest;
  logic [31:0]       r_dma_length;

  logic [2:0]        w_pick;
  logic              w_pick_vld;
  logic [1:0]        w_pick_id;
  logic [31:0]       w_len_sel;
  logic [N_CH-1:0]   w_grant_oh;
  logic              w_load;
  logic              w_start_nxt;
  logic [N_CH-1:0]   w_ack_nxt;
  logic [N_CH-1:0]   w_done_nxt;
  logic              w_wd_fire;

  // Scan from lowest to highest priority so the highest-priority requester wins.
  function automatic logic [2:0] f_pick(input logic [N_CH-1:0] req, input logic [1:0] last);
    logic [1:0] idx;
    f_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'(i + 1);
      if (req[idx]) f_pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [31:0] f_round4(input logic [31:0] len);
    if (len > 32'hFFFF_FFFC) return 32'hFFFF_FFFC;
    return (len + 32'd3) & ~32'd3;
  endfunction

  assign w_pick     = f_pick(ch_req, r_last_grant);
  assign w_pick_vld = w_pick[2];
  assign w_pick_id  = w_pick[1:0];
  assign w_len_sel  = ch_length[{w_pick_id, 5'd0} +: 32];
  assign w_grant_oh = N_CH'(1) << r_grant;

`ifdef DMA_ARB_WATCHDOG_EN
  localparam logic [31:0] C_WD_LAST = 32'(WD_LIMIT - 1);

  logic [31:0] r_wd_cnt;
  logic        r_timeout;

  assign w_wd_fire = ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) &&
                     (r_wd_cnt == C_WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ISSUE)
        r_wd_cnt <= '0;
      else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE))
        r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_wd_fire) r_timeout <= 1'b1;
    end
  end

  assign dma_timeout = r_timeout;
`else
  assign w_wd_fire   = 1'b0;
  assign dma_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start_nxt = 1'b0;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    case (r_state)
      IDLE: begin
        // Arbitrate only while the engine is idle so a start never lands on a busy engine.
        if (w_pick_vld && !dma_busy) begin
          w_load      = 1'b1;
          w_state_nxt = (w_len_sel == 32'd0) ? COMPLETE : ISSUE;
        end
      end
      ISSUE: begin
        w_start_nxt = 1'b1;
        w_ack_nxt   = w_grant_oh;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (dma_busy)  w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (!dma_busy) w_state_nxt = COMPLETE;
      COMPLETE: begin
        w_done_nxt = w_grant_oh;
        if (r_dma_length == 32'd0) w_ack_nxt = w_grant_oh;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_wd_fire) w_state_nxt = COMPLETE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 2'd3;
      r_grant      <= 2'd0;
      r_ch_ack     <= '0;
      r_ch_done    <= '0;
      r_arb_busy   <= 1'b0;
      r_dma_start  <= 1'b0;
      r_dma_src    <= '0;
      r_dma_dest   <= '0;
      r_dma_length <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch_ack    <= w_ack_nxt;
      r_ch_done   <= w_done_nxt;
      r_dma_start <= w_start_nxt;
      r_arb_busy  <= (w_state_nxt != IDLE);
      if (w_load) begin
        r_grant      <= w_pick_id;
        r_dma_src    <= ch_src_addr[{w_pick_id, 5'd0} +: 32];
        r_dma_dest   <= ch_dest_addr[{w_pick_id, 5'd0} +: 32];
        r_dma_length <= f_round4(w_len_sel);
      end
      if (r_state == COMPLETE) r_last_grant <= r_grant;
    end
  end

  assign ch_ack        = r_ch_ack;
  assign ch_done       = r_ch_done;
  assign grant_id      = r_grant;
  assign arb_busy      = r_arb_busy;
  assign dma_start     = r_dma_start;
  assign dma_src_addr  = r_dma_src;
  assign dma_dest_addr = r_dma_dest;
  assign dma_length    = r_dma_length;

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dma_arbiter : scoreboard bench for dma_arbiter with a simple DMA model|
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_dma_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ch_req;
  logic [127:0] ch_src_addr, ch_dest_addr, ch_length;
  logic [3:0]   ch_ack, ch_done;
  logic [1:0]   grant_id;
  logic         arb_busy, dma_start;
  logic [31:0]  dma_src_addr, dma_dest_addr, dma_length;
  logic         dma_busy;
  logic         dma_timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        start;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [1:0]  gid;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  dma_arbiter #(.N_CH(4), .WD_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req),
    .ch_src_addr(ch_src_addr), .ch_dest_addr(ch_dest_addr), .ch_length(ch_length),
    .ch_ack(ch_ack), .ch_done(ch_done), .grant_id(grant_id), .arb_busy(arb_busy),
    .dma_start(dma_start), .dma_src_addr(dma_src_addr), .dma_dest_addr(dma_dest_addr),
    .dma_length(dma_length), .dma_busy(dma_busy), .dma_timeout(dma_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DMA engine model: goes busy the cycle after a start, stays busy busy_len cycles.
  int   busy_len = 3;
  int   busy_cnt = 0;
  logic hang     = 1'b0;
  logic start_q  = 1'b0;
  logic rst_q    = 1'b0;
  initial begin
    dma_busy = 1'b0;
    forever begin
      @(negedge clk);
      start_q = dma_start;
      rst_q   = reset;
      @(posedge clk);
      #1;
      if (rst_q) begin
        dma_busy = 1'b0;
        busy_cnt = 0;
      end else if (start_q) begin
        dma_busy = 1'b1;
        busy_cnt = busy_len;
      end else if (dma_busy && !hang) begin
        if (busy_cnt <= 1) dma_busy = 1'b0;
        else busy_cnt--;
      end
    end
  end

  // Monitor: every cycle the DUT shows an ack/done/start event, pop and compare.
  always @(negedge clk) begin
    if (!reset) begin
      if (dma_start) begin
        checks++;
        if (dma_busy) begin
          failures++;
          $display("FAIL start_while_busy got dma_busy=1 at cyc=%0d required 0", cyc);
        end
      end
      if (dma_start || (ch_ack != 4'd0) || (ch_done != 4'd0)) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got start=%b ack=%b done=%b gid=%0d cyc=%0d required none",
                   dma_start, ch_ack, ch_done, grant_id, cyc);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.start !== dma_start || mon_e.ack !== ch_ack || mon_e.done !== ch_done ||
              mon_e.gid !== grant_id || mon_e.src !== dma_src_addr || mon_e.dst !== dma_dest_addr ||
              mon_e.len !== dma_length || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
            failures++;
            $display("FAIL event got start=%b ack=%b done=%b gid=%0d src=%h dst=%h len=%h cyc=%0d required start=%b ack=%b done=%b gid=%0d src=%h dst=%h len=%h cyc=%0d",
                     dma_start, ch_ack, ch_done, grant_id, dma_src_addr, dma_dest_addr, dma_length, cyc,
                     mon_e.start, mon_e.ack, mon_e.done, mon_e.gid, mon_e.src, mon_e.dst, mon_e.len, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic set_desc(input int ch, input logic [31:0] len);
    ch_src_addr[32*ch +: 32]  = 32'h1000_0000 + 32'(ch * 32'h100);
    ch_dest_addr[32*ch +: 32] = 32'h2000_0000 + 32'(ch * 32'h100);
    ch_length[32*ch +: 32]    = len;
  endtask

  task automatic push_xfer(input int ch, input logic [31:0] len_exp, input int start_cyc);
    exp_t e;
    e.start = 1'b1;
    e.ack   = 4'(1 << ch);
    e.done  = 4'd0;
    e.gid   = 2'(ch);
    e.src   = 32'h1000_0000 + 32'(ch * 32'h100);
    e.dst   = 32'h2000_0000 + 32'(ch * 32'h100);
    e.len   = len_exp;
    e.cyc   = start_cyc;
    q.push_back(e);
    e.start = 1'b0;
    e.ack   = 4'd0;
    e.done  = 4'(1 << ch);
    e.cyc   = -1;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // kind: 0 = ack on mask, 1 = done on mask, 2 = dma_busy high
  task automatic wait_on(input int kind, input logic [3:0] mask, input int limit, input string name);
    for (int n = 0; n < limit; n++) begin
      @(posedge clk);
      #1;
      if ((kind == 0 && (ch_ack & mask) != 4'd0) ||
          (kind == 1 && (ch_done & mask) != 4'd0) ||
          (kind == 2 && dma_busy)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s timeout got no event in %0d cycles required event", name, limit);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(ch_ack), 32'd0);
    chk({tag, "_done"},  32'(ch_done), 32'd0);
    chk({tag, "_start"}, 32'(dma_start), 32'd0);
    chk({tag, "_abusy"}, 32'(arb_busy), 32'd0);
    chk({tag, "_gid"},   32'(grant_id), 32'd0);
    chk({tag, "_src"},   dma_src_addr, 32'd0);
    chk({tag, "_dst"},   dma_dest_addr, 32'd0);
    chk({tag, "_len"},   dma_length, 32'd0);
    chk({tag, "_tmo"},   32'(dma_timeout), 32'd0);
  endtask

  initial begin
    int   k;
    exp_t z;
    reset        = 1'b1;
    ch_req       = 4'd0;
    ch_src_addr  = '0;
    ch_dest_addr = '0;
    ch_length    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Round robin with all four channels requesting continuously.
    set_desc(0, 32'd16);
    set_desc(1, 32'd6);
    set_desc(2, 32'hFFFF_FFFF);
    set_desc(3, 32'd20);
    busy_len = 3;
    @(posedge clk);
    #1 k = cyc;
    push_xfer(0, 32'd16, k + 2);
    push_xfer(1, 32'd8, -1);
    push_xfer(2, 32'hFFFF_FFFC, -1);
    push_xfer(3, 32'd20, -1);
    push_xfer(0, 32'd16, -1);
    ch_req = 4'hF;
    for (int i = 0; i < 5; i++) wait_on(1, 4'hF, 100, "rr_done");
    ch_req = 4'h0;
    repeat (4) @(posedge clk);

    // Single channel 0, len 16, engine busy 10 cycles; descriptor edits after ack are ignored.
    busy_len = 10;
    set_desc(0, 32'd16);
    #1 k = cyc;
    push_xfer(0, 32'd16, k + 2);
    ch_req = 4'b0001;
    wait_on(0, 4'b0001, 20, "single_ack");
    ch_req = 4'b0000;
    ch_length[31:0]   = 32'h0000_0040;
    ch_src_addr[31:0] = 32'hDEAD_BEEF;
    wait_on(1, 4'b0001, 50, "single_done");
    @(negedge clk);
    chk("single_tmo", 32'(dma_timeout), 32'd0);
    repeat (3) @(posedge clk);

    // Zero-length descriptor on channel 2: ack and done together, no start.
    set_desc(2, 32'd0);
    #1 k = cyc;
    z.start = 1'b0; z.ack = 4'b0100; z.done = 4'b0100; z.gid = 2'd2;
    z.src = 32'h1000_0200; z.dst = 32'h2000_0200; z.len = 32'd0; z.cyc = k + 2;
    q.push_back(z);
    ch_req = 4'b0100;
    wait_on(0, 4'b0100, 20, "zero_ack");
    ch_req = 4'b0000;
    repeat (4) @(posedge clk);

    // Rounding and saturation: last grant was 2, so channel 3 precedes channel 1.
    busy_len = 3;
    set_desc(1, 32'd6);
    set_desc(3, 32'hFFFF_FFFF);
    #1 k = cyc;
    push_xfer(3, 32'hFFFF_FFFC, k + 2);
    push_xfer(1, 32'd8, -1);
    ch_req = 4'b1010;
    wait_on(0, 4'b1000, 20, "round_ack3");
    ch_req[3] = 1'b0;
    wait_on(0, 4'b0010, 50, "round_ack1");
    ch_req[1] = 1'b0;
    wait_on(1, 4'b0010, 50, "round_done1");
    repeat (3) @(posedge clk);

    // Reset a few cycles into WAIT_DONE: abort with no done, round robin restarts at 0.
    busy_len = 40;
    set_desc(2, 32'd100);
    #1 k = cyc;
    z.start = 1'b1; z.ack = 4'b0100; z.done = 4'b0000; z.gid = 2'd2;
    z.src = 32'h1000_0200; z.dst = 32'h2000_0200; z.len = 32'd100; z.cyc = k + 2;
    q.push_back(z);
    ch_req = 4'b0100;
    wait_on(0, 4'b0100, 20, "abort_ack");
    ch_req = 4'b0000;
    wait_on(2, 4'b0000, 20, "abort_busy");
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    repeat (3) @(posedge clk);

    busy_len = 3;
    set_desc(0, 32'd4);
    set_desc(1, 32'd1);
    set_desc(2, 32'd12);
    #1 k = cyc;
    push_xfer(0, 32'd4, k + 2);
    push_xfer(1, 32'd4, -1);
    push_xfer(2, 32'd12, -1);
    ch_req = 4'b0111;
    wait_on(0, 4'b0001, 20, "post_ack0");
    ch_req[0] = 1'b0;
    wait_on(0, 4'b0010, 50, "post_ack1");
    ch_req[1] = 1'b0;
    wait_on(0, 4'b0100, 50, "post_ack2");
    ch_req[2] = 1'b0;
    wait_on(1, 4'b0100, 50, "post_done2");
    repeat (3) @(posedge clk);

`ifdef DMA_ARB_WATCHDOG_EN
    // Engine never drops busy: the watchdog completes the transfer and flags a timeout.
    hang = 1'b1;
    set_desc(3, 32'd16);
    #1 k = cyc;
    push_xfer(3, 32'd16, k + 2);
    ch_req = 4'b1000;
    wait_on(0, 4'b1000, 20, "wd_ack");
    ch_req = 4'b0000;
    wait_on(1, 4'b1000, 40, "wd_done");
    @(negedge clk);
    chk("wd_tmo_set", 32'(dma_timeout), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("wd_tmo_sticky", 32'(dma_timeout), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("wd_tmo_clear", 32'(dma_timeout), 32'd0);
`endif

    repeat (5) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of requester channels, fixed at 4 in this revision.
REQ-002 SHALL have parameter WD_LIMIT, default 1024: watchdog cycle limit, used only when DMA_ARB_WATCHDOG_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ch_req  input  4  per-channel level request, held until ch_ack.
REQ-006 SHALL have port ch_src_addr  input  128  4x32 source addresses; channel i is bits [32i+31:32i].
REQ-007 SHALL have port ch_dest_addr  input  128  4x32 destination addresses, packed as ch_src_addr.
REQ-008 SHALL have port ch_length  input  128  4x32 byte lengths, packed as ch_src_addr.
REQ-009 SHALL have port ch_ack  output  4  one-cycle pulse: descriptor accepted.
REQ-010 SHALL have port ch_done  output  4  one-cycle pulse: transfer finished.
REQ-011 SHALL have port grant_id  output  2  channel currently owning the DMA.
REQ-012 SHALL have port arb_busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port dma_start  output  1  start strobe to the DMA engine.
REQ-014 SHALL have port dma_src_addr, dma_dest_addr, dma_length  output  32 each  descriptor presented to the DMA engine.
REQ-015 SHALL have port dma_busy  input  1  busy flag from the DMA engine.
REQ-016 SHALL have port dma_timeout  output  1  sticky watchdog error flag.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE; all outputs SHALL be registered.
REQ-018 In IDLE with any ch_req bit high, SHALL select the winner round-robin, starting from (last_grant+1) mod 4, where last_grant resets to 3 (channel 0 highest after reset).
REQ-019 On selection, SHALL latch that channel's src, dest and length into dma_src_addr/dma_dest_addr/dma_length and set grant_id in the same edge.
REQ-020 SHALL round dma_length up to a multiple of 4 ((len+3) with bits [1:0] cleared); for len > 0xFFFFFFFC it SHALL saturate to 0xFFFFFFFC.
REQ-021 For latched length 0, SHALL go IDLE -> COMPLETE and SHALL NOT assert dma_start; ch_ack and ch_done SHALL both pulse in the COMPLETE cycle.
REQ-022 Otherwise, SHALL go IDLE -> ISSUE; in ISSUE, dma_start and ch_ack[grant_id] SHALL be high for exactly one cycle, then -> WAIT_BUSY.
REQ-023 In WAIT_BUSY, SHALL stay until dma_busy=1, then -> WAIT_DONE; in WAIT_DONE, SHALL stay until dma_busy=0, then -> COMPLETE.
REQ-024 In COMPLETE, SHALL pulse ch_done[grant_id] for one cycle, set last_grant=grant_id, and -> IDLE.
REQ-025 Request-to-dma_start latency SHALL be 2 cycles; a channel whose ch_req is still high after its done SHALL re-enter arbitration with lowest priority.
REQ-026 Changes to ch_* descriptor inputs after selection SHALL NOT affect the transfer in flight.
REQ-027 dma_start SHALL never be asserted while dma_busy=1 or while arb_busy was high before ISSUE.

Reset
REQ-028 On reset=1 at a clock edge, SHALL enter IDLE, set last_grant=3, and clear ch_ack, ch_done, dma_start, arb_busy, grant_id, dma_src_addr, dma_dest_addr, dma_length, dma_timeout and the watchdog counter to 0.
REQ-029 Reset mid-transfer SHALL abort without any ch_done pulse; reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-030 Macro DMA_ARB_WATCHDOG_EN defined: a counter SHALL clear on entry to WAIT_BUSY and increment each cycle in WAIT_BUSY/WAIT_DONE; on reaching WD_LIMIT, the block SHALL set dma_timeout (sticky until reset), go to COMPLETE, and pulse ch_done normally.
REQ-031 Macro undefined: no counter SHALL exist, dma_timeout SHALL be tied 0, and WAIT states SHALL wait indefinitely.

Verification
REQ-032 The bench SHALL drive ch_req=0001, len=16, with the DMA model busy for 10 cycles -> dma_start 2 cycles after req, ch_ack[0] in the same cycle, one ch_done[0], dma_length=16.
REQ-033 The bench SHALL hold ch_req=1111 with all channels re-requesting -> grant order 0,1,2,3,0, with one ch_done per grant.
REQ-034 The bench SHALL drive ch_length[ch2]=0 -> ch_ack[2] and ch_done[2] in the same cycle, with dma_start never high.
REQ-035 The bench SHALL drive lengths 6 and 0xFFFFFFFF -> dma_length 8 and 0xFFFFFFFC respectively.
REQ-036 The bench SHALL assert reset 3 cycles into WAIT_DONE -> all outputs 0 the next cycle, no ch_done, and the next grant goes to channel 0.
REQ-037 With DMA_ARB_WATCHDOG_EN and WD_LIMIT=8, the bench SHALL hold dma_busy high forever -> dma_timeout=1, ch_done pulses, and dma_timeout stays 1 until reset.
